// File: rtl/barrel_pkg.sv
// rtl/barrel_pkg.sv - shared types and default geometry for the barrel hit detector
package barrel_pkg;

    localparam int NUM_BARRELS  = 10;
    localparam int DONKEY_W     = 64;
    localparam int DONKEY_H     = 64;
    localparam int BARREL_W     = 32;
    localparam int BARREL_H     = 32;
    localparam int GRACE_CYCLES = 65_000_000;

    typedef logic [10:0] pos_t;
    typedef pos_t [NUM_BARRELS-1:0] barrel_pos_t;

    typedef enum logic [1:0] {
        DISABLED,
        ARMED,
        GRACE
    } hit_state_t;

endpackage

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - combinational strict-overlap test of two axis-aligned boxes
// Ports:
//   a_x, a_y  top-left of box A (size A_W x A_H)
//   b_x, b_y  top-left of box B (size B_W x B_H)
//   overlap   high when the boxes share interior area (touching edges do not count)
module box_overlap
    import barrel_pkg::*;
#(
    parameter int A_W = 64,
    parameter int A_H = 64,
    parameter int B_W = 32,
    parameter int B_H = 32
) (
    input  pos_t a_x,
    input  pos_t a_y,
    input  pos_t b_x,
    input  pos_t b_y,
    output logic overlap
);

    // One extra bit so position + size can never wrap.
    logic [11:0] ax;
    logic [11:0] ay;
    logic [11:0] bx;
    logic [11:0] by;

    always_comb begin
        ax = {1'b0, a_x};
        ay = {1'b0, a_y};
        bx = {1'b0, b_x};
        by = {1'b0, b_y};
        overlap = (ax < (bx + 12'(B_W))) && (bx < (ax + 12'(A_W))) &&
                  (ay < (by + 12'(B_H))) && (by < (ay + 12'(A_H)));
    end

endmodule

// File: rtl/barrel_hit_detector.sv
// rtl/barrel_hit_detector.sv - per-barrel overlap-entry pulses with optional post-hit grace (BARREL_HIT_GRACE_EN)
// Ports:
//   clk, rst             game clock, synchronous active-high reset
//   game_en              low freezes and clears detection
//   xpos/ypos_donkey     donkey top-left
//   xpos/ypos_barrel     barrel top-left per slot
//   barrel_active        slot is on screen
//   hit                  one-cycle pulse per newly overlapping barrel
//   grace_active         high while new hits are suppressed
module barrel_hit_detector
    import barrel_pkg::*;
#(
    parameter int NUM_BARRELS  = barrel_pkg::NUM_BARRELS,
    parameter int DONKEY_W     = barrel_pkg::DONKEY_W,
    parameter int DONKEY_H     = barrel_pkg::DONKEY_H,
    parameter int BARREL_W     = barrel_pkg::BARREL_W,
    parameter int BARREL_H     = barrel_pkg::BARREL_H,
    parameter int GRACE_CYCLES = barrel_pkg::GRACE_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   game_en,
    input  pos_t                   xpos_donkey,
    input  pos_t                   ypos_donkey,
    input  pos_t [NUM_BARRELS-1:0] xpos_barrel,
    input  pos_t [NUM_BARRELS-1:0] ypos_barrel,
    input  logic [NUM_BARRELS-1:0] barrel_active,
    output logic [NUM_BARRELS-1:0] hit,
    output logic                   grace_active
);

    logic [NUM_BARRELS-1:0] ovl_raw;
    logic [NUM_BARRELS-1:0] ovl;

    for (genvar gi = 0; gi < NUM_BARRELS; gi++) begin : g_box
        box_overlap #(
            .A_W (DONKEY_W),
            .A_H (DONKEY_H),
            .B_W (BARREL_W),
            .B_H (BARREL_H)
        ) u_box (
            .a_x     (xpos_donkey),
            .a_y     (ypos_donkey),
            .b_x     (xpos_barrel[gi]),
            .b_y     (ypos_barrel[gi]),
            .overlap (ovl_raw[gi])
        );
    end

    // An inactive slot never overlaps, so dropping it clears history silently
    // and re-activating it while overlapping reads as a fresh entry.
    assign ovl = ovl_raw & barrel_active;

    hit_state_t             state_q, state_d;
    logic [NUM_BARRELS-1:0] ovl_q, ovl_d;
    logic [NUM_BARRELS-1:0] ovl_prev_q, ovl_prev_d;
    logic [NUM_BARRELS-1:0] hit_q, hit_d;
    logic [NUM_BARRELS-1:0] rise;

    assign rise = ovl_q & ~ovl_prev_q;

`ifdef BARREL_HIT_GRACE_EN
    localparam int CNT_W = $clog2(GRACE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grace_q, grace_d;
`else
    // Grace length is meaningless without the grace window.
    localparam int unused_grace_cycles = GRACE_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        ovl_d      = ovl;
        ovl_prev_d = ovl_q;
        hit_d      = '0;
`ifdef BARREL_HIT_GRACE_EN
        cnt_d      = cnt_q;
        grace_d    = 1'b0;
`endif
        if (!game_en) begin
            state_d    = DISABLED;
            ovl_d      = '0;
            ovl_prev_d = '0;
`ifdef BARREL_HIT_GRACE_EN
            cnt_d      = '0;
`endif
        end else begin
            case (state_q)
                DISABLED: begin
                    // History stays clear for the enabling edge, so a barrel
                    // already overlapping at enable is seen as an entry.
                    state_d    = ARMED;
                    ovl_d      = '0;
                    ovl_prev_d = '0;
                end
                ARMED: begin
                    hit_d = rise;
`ifdef BARREL_HIT_GRACE_EN
                    if (|rise) begin
                        cnt_d   = CNT_W'(GRACE_CYCLES - 1);
                        grace_d = 1'b1;
                        state_d = GRACE;
                    end
`endif
                end
`ifdef BARREL_HIT_GRACE_EN
                GRACE: begin
                    // History keeps tracking, so entries made during grace
                    // never produce a late hit.
                    if (cnt_q == '0) begin
                        state_d = ARMED;
                    end else begin
                        cnt_d   = cnt_q - CNT_W'(1);
                        grace_d = 1'b1;
                    end
                end
`endif
                default: state_d = DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DISABLED;
            ovl_q      <= '0;
            ovl_prev_q <= '0;
            hit_q      <= '0;
`ifdef BARREL_HIT_GRACE_EN
            cnt_q      <= '0;
            grace_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ovl_q      <= ovl_d;
            ovl_prev_q <= ovl_prev_d;
            hit_q      <= hit_d;
`ifdef BARREL_HIT_GRACE_EN
            cnt_q      <= cnt_d;
            grace_q    <= grace_d;
`endif
        end
    end

    assign hit = hit_q;

`ifdef BARREL_HIT_GRACE_EN
    assign grace_active = grace_q;
`else
    assign grace_active = 1'b0;
`endif

endmodule

// File: tb/tb_barrel_hit_detector.sv
// tb/tb_barrel_hit_detector.sv - randomized scoreboard bench for barrel_hit_detector
module tb_barrel_hit_detector;
    import barrel_pkg::*;

    localparam int NB = 10;
    localparam int G  = 8;
`ifdef BARREL_HIT_GRACE_EN
    localparam bit GRACE_EN = 1'b1;
`else
    localparam bit GRACE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          game_en;
    pos_t          xd, yd;
    pos_t [NB-1:0] xb, yb;
    logic [NB-1:0] act;
    logic [NB-1:0] hit;
    logic          grace_active;

    always #5 clk = ~clk;

    barrel_hit_detector #(
        .NUM_BARRELS  (NB),
        .GRACE_CYCLES (G)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .game_en       (game_en),
        .xpos_donkey   (xd),
        .ypos_donkey   (yd),
        .xpos_barrel   (xb),
        .ypos_barrel   (yb),
        .barrel_active (act),
        .hit           (hit),
        .grace_active  (grace_active)
    );

    typedef struct packed {
        logic [NB-1:0] hit;
        logic          ga;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    function automatic bit overlaps(int dx, int dy, int bx, int by);
        return (dx < bx + 32) && (bx < dx + 64) && (dy < by + 32) && (by < dy + 64);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
    endtask

    // Reference: a hit at edge m reports barrels that overlapped at edge m-1
    // but not at m-2, counting only samples taken while the game was running
    // for two consecutive edges; after a hit, the next G edges report none.
    initial begin : model
        bit            ok, ok_prev;
        bit            ga_prev;
        logic [NB-1:0] ov, eff_cur, eff1, eff2, rise;
        int            grace_end;
        exp_t          e;
        ok_prev   = 1'b0;
        ga_prev   = 1'b0;
        eff1      = '0;
        eff2      = '0;
        grace_end = 0;
        forever begin
            @(posedge clk);
            ok = !rst && game_en;
            for (int i = 0; i < NB; i++)
                ov[i] = act[i] && overlaps(int'(xd), int'(yd), int'(xb[i]), int'(yb[i]));
            eff_cur = (ok && ok_prev) ? ov : '0;
            rise    = eff1 & ~eff2;
            e       = '0;
            if (ok && ok_prev) begin
                if (GRACE_EN && ga_prev) begin
                    e.ga = (cyc < grace_end);
                end else begin
                    e.hit = rise;
                    if (GRACE_EN && rise != '0) begin
                        grace_end = cyc + G;
                        e.ga      = 1'b1;
                    end
                end
            end
            exp_q.push_back(e);
            ga_prev = e.ga;
            eff2    = eff1;
            eff1    = eff_cur;
            ok_prev = ok;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("hit", 32'(hit), 32'(e.hit));
                check("grace_active", 32'(grace_active), 32'(e.ga));
            end
            cyc++;
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_b(int i, int x, int y, bit a);
        xb[i]  = pos_t'(x);
        yb[i]  = pos_t'(y);
        act[i] = a;
    endtask

    task automatic park_all();
        for (int i = 0; i < NB; i++) set_b(i, 1500, 1500, 1'b0);
    endtask

    function automatic int near(int c);
        int v;
        v = c + int'($urandom_range(0, 110)) - 40;
        if (v < 0) v = 0;
        if (v > 2047) v = 2047;
        return v;
    endfunction

    initial begin : stim
        int dxi, dyi;
        rst     = 1'b1;
        game_en = 1'b0;
        xd      = 11'd300;
        yd      = 11'd200;
        park_all();
        step(3);

        // Already overlapping at enable
        rst = 1'b0;
        set_b(0, 330, 220, 1'b1);
        step(2);
        game_en = 1'b1;
        step(14);

        // Edge touch then one-pixel overlap
        set_b(1, 364, 200, 1'b1);
        step(20);
        set_b(1, 363, 200, 1'b1);
        step(14);

        // Two barrels entering together
        set_b(0, 1500, 1500, 1'b0);
        set_b(1, 1500, 1500, 1'b0);
        step(3);
        set_b(2, 310, 210, 1'b1);
        set_b(5, 280, 190, 1'b1);
        step(14);

        // Entry during grace, exit and re-entry after grace
        set_b(6, 320, 230, 1'b1);
        step(3);
        set_b(7, 340, 240, 1'b1);
        step(12);
        set_b(7, 900, 900, 1'b1);
        step(2);
        set_b(7, 340, 240, 1'b1);
        step(12);

        // Reset mid-grace with overlap held
        set_b(8, 1500, 1500, 1'b1);
        step(2);
        set_b(8, 300, 200, 1'b1);
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(12);

        // Enter / exit / enter every two cycles
        park_all();
        step(12);
        for (int k = 0; k < 2; k++) begin
            set_b(3, 330, 230, 1'b1);
            step(2);
            set_b(3, 1000, 230, 1'b1);
            step(2);
        end
        set_b(3, 330, 230, 1'b1);
        step(12);

        // Deactivate while overlapping, then reactivate
        act[3] = 1'b0;
        step(4);
        act[3] = 1'b1;
        step(12);

        // Game disable while overlapping, then near the 11-bit limit
        game_en = 1'b0;
        step(3);
        park_all();
        xd      = 11'd2000;
        yd      = 11'd2000;
        game_en = 1'b1;
        step(2);
        set_b(4, 2040, 2040, 1'b1);
        set_b(9, 2047, 1936, 1'b1);
        step(14);

        // Random traffic clustered around the donkey
        dxi = 300;
        dyi = 200;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 99) == 0) begin
                dxi = int'($urandom_range(0, 2047));
                dyi = int'($urandom_range(0, 2047));
                xd  = pos_t'(dxi);
                yd  = pos_t'(dyi);
            end
            rst     = ($urandom_range(0, 299) == 0);
            game_en = ($urandom_range(0, 59) != 0);
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 5) == 0)
                    set_b(i, near(dxi), near(dyi), act[i]);
                if ($urandom_range(0, 29) == 0)
                    act[i] = ~act[i];
            end
            step(1);
        end

        rst     = 1'b0;
        game_en = 1'b0;
        step(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
